// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and defaults for the unified-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Which requester owns the read data returning from Memory next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  // Consecutive denials the low-priority port tolerates before it is forced through.
  localparam int unsigned MAX_WAIT_DEF = 4;

  // Width of a counter that must represent 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_age_ctr.sv
// Purpose: saturating count of consecutive cycles port B was denied; flags when B must win.
// Latency: age_hit is a registered state, visible the cycle after the denial that reaches MAX_WAIT.
// Backpressure: none; it only observes b_req/b_gnt and never stalls anything.
module mem_arb_age_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic b_req,
  input  logic b_gnt,
  output logic age_hit
);

  localparam int unsigned       CW      = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0]     MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_d;

  // Count denials while B keeps asking; any grant or withdrawal restarts the streak.
  always_comb begin
    wait_cnt_d = '0;
    if (b_req && !b_gnt) begin
      wait_cnt_d = (wait_cnt_q == MAX_CNT) ? MAX_CNT : wait_cnt_q + 1'b1;
    end
  end

  // Streak register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign age_hit = (wait_cnt_q == MAX_CNT);

  // The counter can never run past its ceiling.
  a_cnt_range : assert property (@(posedge clk) disable iff (rst) wait_cnt_q <= MAX_CNT);

endmodule : mem_arb_age_ctr

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between CPU (A, priority) and DMA/debug (B, aged).
// Latency: grant and memory drive are combinational; read data returns one cycle after grant.
// Backpressure: a requester holds req until its gnt; B is forced through after MAX_WAIT denials.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  // Port A: CPU
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_adr,
  input  logic [DW-1:0] a_wd,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rd,
  // Port B: DMA / debug loader
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_adr,
  input  logic [DW-1:0] b_wd,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rd,
  // Memory side
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  logic   age_hit;
  owner_e rd_owner_q;
  owner_e rd_owner_d;
  logic [DW-1:0] hold_a_q;
  logic [DW-1:0] hold_b_q;

  // Starvation guard for the low-priority port.
  mem_arb_age_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk     (clk),
    .rst     (rst),
    .b_req   (b_req),
    .b_gnt   (b_gnt),
    .age_hit (age_hit)
  );

  // A wins by default; B wins when A is idle or B has waited long enough.
  assign b_gnt = b_req & (~a_req | age_hit);
  assign a_gnt = a_req & ~b_gnt;

  // Drive Memory from the granted port; park on a harmless read of address 0 otherwise.
  always_comb begin
    mem_adr = '0;
    mem_we  = 1'b0;
    mem_wd  = '0;
    if (a_gnt) begin
      mem_adr = a_adr;
      mem_we  = a_we;
      mem_wd  = a_wd;
    end else if (b_gnt) begin
      mem_adr = b_adr;
      mem_we  = b_we;
      mem_wd  = b_wd;
    end
  end

  // Tag the read issued this cycle so next cycle's Memory output goes to the right port.
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (a_gnt && !a_we) begin
      rd_owner_d = OWN_A;
    end else if (b_gnt && !b_we) begin
      rd_owner_d = OWN_B;
    end
  end

  // Owner tag and per-port held copies of the last delivered read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q <= OWN_NONE;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      if (rd_owner_q == OWN_A) begin
        hold_a_q <= mem_rd;
      end
      if (rd_owner_q == OWN_B) begin
        hold_b_q <= mem_rd;
      end
    end
  end

  // A reset arriving while read data is in flight drops that data at the port boundary too,
  // so the requester never sees a pulse for an access the reset has cancelled.
  assign a_rvalid = (rd_owner_q == OWN_A) & ~rst;
  assign b_rvalid = (rd_owner_q == OWN_B) & ~rst;

  assign a_rd = a_rvalid ? mem_rd : (rst ? '0 : hold_a_q);
  assign b_rd = b_rvalid ? mem_rd : (rst ? '0 : hold_b_q);

  // Single-port memory: never two accesses, never two read returns in one cycle.
  a_one_gnt    : assert property (@(posedge clk) !(a_gnt && b_gnt));
  a_one_rvalid : assert property (@(posedge clk) !(a_rvalid && b_rvalid));

endmodule : mem_port_arbiter
